// File: rtl/cam_clk_pkg.sv
// +----------------------------------------------------------------------------+
// | cam_clk_pkg                                                                |
// | Shared types and widths for the camera clock / power-up sequencer.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cam_clk_pkg;
  localparam int DIV_W   = 10;
  localparam int TIMER_W = 24;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    CLK_ON   = 3'd1,
    RST_HOLD = 3'd2,
    BOOT     = 3'd3,
    READY    = 3'd4
  } seq_state_t;
endpackage

`default_nettype wire

// File: rtl/xclk_gen.sv
// +----------------------------------------------------------------------------+
// | xclk_gen                                                                   |
// | Half-period counter and toggle producing XCLK; ratio reloads glitch-free.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module xclk_gen #(
  parameter int               DIV_W       = 10,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_xclk,
  output logic             o_fall_evt
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_xclk;
  logic             w_wrap;

  assign w_wrap     = i_en && (r_cnt == r_div);
  assign o_fall_evt = w_wrap && r_xclk;
  assign o_xclk     = r_xclk;

  // A new ratio only takes effect where a low phase starts from zero, so no runt pulse.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_div  <= DEFAULT_DIV;
      r_xclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_xclk <= 1'b0;
      if (i_load) begin
        r_div <= i_div;
      end
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_xclk <= ~r_xclk;
      if (i_load && r_xclk) begin
        r_div <= i_div;
      end
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cam_clk_sequencer.sv
// +----------------------------------------------------------------------------+
// | cam_clk_sequencer                                                          |
// | Camera XCLK generation, timed PWDN/RESET power-up and ratio handshake.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cam_clk_sequencer #(
  parameter int                 DIV_W       = cam_clk_pkg::DIV_W,
  parameter logic [DIV_W-1:0]   DEFAULT_DIV = '0,
  parameter logic [23:0]        T_PWDN      = 24'd50000,
  parameter logic [23:0]        T_RST       = 24'd50000,
  parameter logic [23:0]        T_BOOT      = 24'd50000
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             xclk,
  output logic             cam_pwdn,
  output logic             cam_rst_n,
  output logic             cam_ready,
  output logic             busy
);

  import cam_clk_pkg::*;

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_load;
  logic               r_pend_valid;
  logic [DIV_W-1:0]   r_pend_div;
  logic               r_pwdn;
  logic               r_rst_n;
  logic               r_ready;
  logic               r_busy;
  logic               w_gen_en;
  logic               w_fall_evt;
  logic               w_load;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      r_state <= OFF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_timer_load = '0;
    case (r_state)
      OFF:      if (start) w_next = CLK_ON;
      CLK_ON:   if (r_timer == '0) w_next = RST_HOLD;
      RST_HOLD: if (r_timer == '0) w_next = BOOT;
      BOOT:     if (r_timer == '0) w_next = READY;
      READY:    w_next = READY;
      default:  w_next = OFF;
    endcase
    // stop overrides everything, including a simultaneous start
    if (stop) begin
      w_next = OFF;
    end
    case (w_next)
      CLK_ON:   w_timer_load = T_PWDN - TIMER_W'(1);
      RST_HOLD: w_timer_load = T_RST  - TIMER_W'(1);
      BOOT:     w_timer_load = T_BOOT - TIMER_W'(1);
      default:  w_timer_load = '0;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_next != r_state) begin
      r_timer <= w_timer_load;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - TIMER_W'(1);
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      r_pwdn  <= 1'b1;
      r_rst_n <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pwdn  <= (w_next == OFF) || (w_next == CLK_ON);
      r_rst_n <= (w_next == BOOT) || (w_next == READY);
      r_ready <= (w_next == READY);
      r_busy  <= (w_next == CLK_ON) || (w_next == RST_HOLD) || (w_next == BOOT);
    end
  end

  // Divider is held off during OFF and on the stop edge so XCLK lands low at OFF entry.
  assign w_gen_en = (r_state != OFF) && !stop;
  assign w_load   = r_pend_valid && (!w_gen_en || w_fall_evt);

  always_ff @(posedge in_clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_div   <= '0;
    end else if (w_load) begin
      r_pend_valid <= 1'b0;
    end else if (cfg_valid && !r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_div   <= cfg_div;
    end
  end

  xclk_gen #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_xclk_gen (
    .in_clk     (in_clk),
    .reset      (reset),
    .i_en       (w_gen_en),
    .i_load     (w_load),
    .i_div      (r_pend_div),
    .o_xclk     (xclk),
    .o_fall_evt (w_fall_evt)
  );

  assign cfg_ready = !r_pend_valid;
  assign cam_pwdn  = r_pwdn;
  assign cam_rst_n = r_rst_n;
  assign cam_ready = r_ready;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cam_clk_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_cam_clk_sequencer                                                       |
// | Directed vector bench for the camera clock / power-up sequencer.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cam_clk_sequencer;

  logic       in_clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic [9:0] cfg_div;
  logic       cfg_ready;
  logic       xclk;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       cam_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 in_clk = ~in_clk;

  cam_clk_sequencer #(
    .DIV_W       (10),
    .DEFAULT_DIV (10'd0),
    .T_PWDN      (24'd4),
    .T_RST       (24'd8),
    .T_BOOT      (24'd16)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .xclk      (xclk),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .cam_ready (cam_ready),
    .busy      (busy)
  );

  // exp order: {cam_pwdn, cam_rst_n, cam_ready, busy, cfg_ready}
  typedef struct {
    logic       start;
    logic       stop;
    int         n;
    logic [4:0] exp;
    int         xmode;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge in_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {xclk, cam_pwdn, cam_rst_n, cam_ready, busy, cfg_ready};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_x;
    int   k;
    int   t0;
    logic prev_x;

    vt[0] = '{1'b0, 1'b0, 50, 5'b10001, 0};
    vt[1] = '{1'b1, 1'b0, 1,  5'b10011, 1};
    vt[2] = '{1'b0, 1'b0, 3,  5'b10011, 1};
    vt[3] = '{1'b0, 1'b0, 8,  5'b00011, 1};
    vt[4] = '{1'b0, 1'b0, 16, 5'b01011, 1};
    vt[5] = '{1'b0, 1'b0, 4,  5'b01101, 1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    tick(); tick(); tick();
    chk("reset_state", 32'(outs()), 32'(6'b010001));
    reset = 1'b0;

    // Idle after reset, then full power-up with div 0 (xclk high on even cycles).
    for (int i = 0; i < 6; i++) begin
      start = vt[i].start;
      stop  = vt[i].stop;
      if (vt[i].start) cyc = 0;
      for (int j = 0; j < vt[i].n; j++) begin
        tick();
        start = 1'b0;
        stop  = 1'b0;
        exp_x = (vt[i].xmode == 1) ? ((cyc % 2) == 0) : 1'b0;
        chk($sformatf("vec%0d_cyc%0d", i, cyc), 32'(outs()), 32'({exp_x, vt[i].exp}));
      end
    end

    // Ratio change to 3 while READY: applied on the next xclk fall.
    cfg_valid = 1'b1; cfg_div = 10'd3;
    tick();
    cfg_valid = 1'b0;
    chk("cfg3_ready_low", 32'(cfg_ready), 32'd0);
    prev_x = xclk;
    k = 0;
    while (!cfg_ready && k < 10) begin
      prev_x = xclk;
      tick();
      k++;
    end
    chk("cfg3_ready_latency", 32'(k), 32'd2);
    chk("cfg3_fall_at_apply", 32'({prev_x, xclk}), 32'(2'b10));
    t0 = cyc;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("div3_xclk_j%0d", j), 32'(xclk), 32'((j / 4) % 2));
      tick();
    end
    chk("ready_still", 32'(cam_ready), 32'd1);

    // stop from READY, restart, stop in RST_HOLD, start+stop together in OFF.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_ready", 32'(outs()), 32'(6'b010001));
    start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    chk("rst_hold_state", 32'(outs() & 6'b011111), 32'(5'b00011));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_rst_hold", 32'(outs()), 32'(6'b010001));
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_same", 32'(outs()), 32'(6'b010001));
    tick(); tick(); tick();
    chk("start_stop_stays_off", 32'(outs()), 32'(6'b010001));

    // Ratio 5 accepted in OFF, then start.
    cfg_valid = 1'b1; cfg_div = 10'd5;
    tick();
    cfg_valid = 1'b0;
    chk("cfg5_ready_low", 32'(cfg_ready), 32'd0);
    tick();
    chk("cfg5_ready_back", 32'(cfg_ready), 32'd1);
    start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("div5_xclk_c%0d", c), 32'(xclk), 32'(((c - 1) / 6) % 2));
      if (c < 19) tick();
    end
    chk("div5_in_boot", 32'({cam_pwdn, cam_rst_n, busy}), 32'(3'b011));

    // Reset in BOOT with a pending ratio: pending is discarded.
    cfg_valid = 1'b1; cfg_div = 10'd7;
    tick();
    cfg_valid = 1'b0;
    chk("cfg7_pending", 32'(cfg_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_in_boot", 32'(outs()), 32'(6'b010001));
    tick();
    chk("reset_pending_gone", 32'(outs()), 32'(6'b010001));
    start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("default_div_xclk_c%0d", c), 32'(xclk), 32'((c % 2) == 0));
      if (c < 8) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
